// File: rtl/crc_pkg.sv
// Shared definitions for the CRC-8 (poly 0x07) stream feeder and its 2-bit step.
package crc_pkg;

    localparam logic [7:0] CRC8_POLY           = 8'h07;
    localparam logic [7:0] CRC8_INIT_DEFAULT   = 8'h00;
    localparam logic [7:0] CRC8_XOROUT_DEFAULT = 8'h00;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } feeder_state_e;

    // Slice k of a byte, MSB pair first: k=0 -> [7:6], k=3 -> [1:0].
    function automatic logic [1:0] byte_slice(input logic [7:0] b, input logic [1:0] k);
        logic [1:0] s;
        case (k)
            2'd0:    s = b[7:6];
            2'd1:    s = b[5:4];
            2'd2:    s = b[3:2];
            default: s = b[1:0];
        endcase
        return s;
    endfunction

endpackage

// File: rtl/crc8_07.sv
// Combinational 2-bit step of CRC-8 (poly 0x07), data bit 1 processed first.
module crc8_07
    import crc_pkg::*;
(
    input  logic [1:0] data_i,
    input  logic [7:0] crc_i,
    output logic [7:0] crc_o
);

    logic [7:0] crc_mid;

    // Bit 1 of the symbol meets crc[7] first, then bit 0 meets the shifted value.
    assign crc_mid = {crc_i[6:0], 1'b0}   ^ ((crc_i[7]   ^ data_i[1]) ? CRC8_POLY : 8'h00);
    assign crc_o   = {crc_mid[6:0], 1'b0} ^ ((crc_mid[7] ^ data_i[0]) ? CRC8_POLY : 8'h00);

endmodule

// File: rtl/crc8_stream_feeder.sv
// Byte-stream front end: feeds each accepted byte to the 2-bit CRC-8 step as four
// MSB-first symbols and hands the final CRC out over a valid/ready handshake.
module crc8_stream_feeder
    import crc_pkg::*;
#(
    parameter logic [7:0] INIT   = CRC8_INIT_DEFAULT,
    parameter logic [7:0] XOROUT = CRC8_XOROUT_DEFAULT
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       dat_valid_i,
    output logic       dat_ready_o,
    input  logic [7:0] dat_i,
    input  logic       dat_last_i,
    output logic       crc_valid_o,
    input  logic       crc_ready_i,
    output logic [7:0] crc_o,
    output logic       busy_o
);

    feeder_state_e state;
    logic [1:0]    slice_cnt;
    logic [7:0]    byte_q;
    logic          last_q;
    logic [7:0]    crc_q;
    logic [7:0]    crc_next;

    crc8_07 u_step (
        .data_i (byte_slice(byte_q, slice_cnt)),
        .crc_i  (crc_q),
        .crc_o  (crc_next)
    );

    assign crc_o = crc_q ^ XOROUT;

    // NOTE: handshake outputs are registered alongside the state so they never glitch;
    // every register here is updated with non-blocking assignments only.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            slice_cnt   <= 2'd0;
            byte_q      <= 8'h00;
            last_q      <= 1'b0;
            crc_q       <= INIT;
            dat_ready_o <= 1'b1;
            crc_valid_o <= 1'b0;
            busy_o      <= 1'b0;
        end else if (clr_i) begin
            state       <= IDLE;
            slice_cnt   <= 2'd0;
            crc_q       <= INIT;
            dat_ready_o <= 1'b1;
            crc_valid_o <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dat_valid_i && dat_ready_o) begin
                        byte_q      <= dat_i;
                        last_q      <= dat_last_i;
                        slice_cnt   <= 2'd0;
                        state       <= SHIFT;
                        dat_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                    end
                end
                SHIFT: begin
                    crc_q     <= crc_next;
                    slice_cnt <= slice_cnt + 2'd1;
                    if (slice_cnt == 2'd3) begin
                        if (last_q) begin
                            state       <= DONE;
                            crc_valid_o <= 1'b1;
                        end else begin
                            state       <= IDLE;
                            dat_ready_o <= 1'b1;
                            busy_o      <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    if (crc_ready_i) begin
                        crc_q       <= INIT;
                        state       <= IDLE;
                        crc_valid_o <= 1'b0;
                        dat_ready_o <= 1'b1;
                        busy_o      <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    dat_ready_o <= 1'b1;
                    crc_valid_o <= 1'b0;
                    busy_o      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc8_stream_feeder.sv
// Directed bench for crc8_stream_feeder with a bit-serial reference model and a CRC scoreboard.
module tb_crc8_stream_feeder;

    localparam logic [7:0] XOR_X = 8'h55;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clr = 1'b0;
    logic       dat_valid = 1'b0;
    logic [7:0] dat = 8'h00;
    logic       dat_last = 1'b0;
    logic       crc_ready = 1'b0;

    logic       dat_ready_o, crc_valid_o, busy_o;
    logic [7:0] crc_o;
    logic       dat_ready_x, crc_valid_x, busy_x;
    logic [7:0] crc_x;

    int passed = 0;
    int total  = 0;
    logic [7:0] model_crc = 8'h00;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    crc8_stream_feeder #(.INIT(8'h00), .XOROUT(8'h00)) dut (
        .clk_i(clk), .rst_i(rst), .clr_i(clr),
        .dat_valid_i(dat_valid), .dat_ready_o(dat_ready_o), .dat_i(dat), .dat_last_i(dat_last),
        .crc_valid_o(crc_valid_o), .crc_ready_i(crc_ready), .crc_o(crc_o), .busy_o(busy_o)
    );

    crc8_stream_feeder #(.INIT(8'h00), .XOROUT(XOR_X)) dut_x (
        .clk_i(clk), .rst_i(rst), .clr_i(clr),
        .dat_valid_i(dat_valid), .dat_ready_o(dat_ready_x), .dat_i(dat), .dat_last_i(dat_last),
        .crc_valid_o(crc_valid_x), .crc_ready_i(crc_ready), .crc_o(crc_x), .busy_o(busy_x)
    );

    function automatic logic [7:0] crc_ref(input logic [7:0] c_in, input logic [7:0] b);
        logic [7:0] c;
        logic       fb;
        c = c_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[7] ^ b[i];
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
        end
        return c;
    endfunction

    task automatic check_byte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one byte, then verify the 4-cycle not-ready window and the post-byte state.
    task automatic send_byte(input logic [7:0] b, input logic last);
        int n = 0;
        while (!dat_ready_o && n < 20) begin
            tick();
            n++;
        end
        check_bit("ready_before_accept", dat_ready_o, 1'b1);
        dat_valid = 1'b1;
        dat       = b;
        dat_last  = last;
        tick();
        dat_valid = 1'b0;
        dat_last  = 1'b0;
        model_crc = crc_ref(model_crc, b);
        if (last) begin
            exp_q.push_back(model_crc);
            model_crc = 8'h00;
        end
        for (int k = 0; k < 4; k++) begin
            check_bit("ready_low_shift", dat_ready_o, 1'b0);
            check_bit("busy_shift", busy_o, 1'b1);
            check_bit("valid_low_shift", crc_valid_o, 1'b0);
            tick();
        end
        if (last) begin
            check_bit("valid_after_T4", crc_valid_o, 1'b1);
            check_bit("ready_low_done", dat_ready_o, 1'b0);
        end else begin
            check_bit("ready_after_T4", dat_ready_o, 1'b1);
            check_bit("busy_after_T4", busy_o, 1'b0);
        end
    endtask

    // Wait for a CRC, compare against the scoreboard, hold off for hold_cycles, then take it.
    task automatic take_crc(input int hold_cycles);
        int n = 0;
        logic [7:0] exp;
        while (!crc_valid_o && n < 20) begin
            tick();
            n++;
        end
        check_bit("crc_valid_seen", crc_valid_o, 1'b1);
        if (exp_q.size() == 0) begin
            check_bit("scoreboard_nonempty", 1'b0, 1'b1);
            return;
        end
        exp = exp_q.pop_front();
        check_byte("crc_o", crc_o, exp);
        check_byte("crc_o_xorout", crc_x, exp ^ XOR_X);
        for (int k = 0; k < hold_cycles; k++) begin
            tick();
            check_bit("hold_valid", crc_valid_o, 1'b1);
            check_byte("hold_crc", crc_o, exp);
            check_bit("hold_ready_low", dat_ready_o, 1'b0);
        end
        crc_ready = 1'b1;
        tick();
        crc_ready = 1'b0;
        check_bit("valid_dropped", crc_valid_o, 1'b0);
        check_bit("idle_ready", dat_ready_o, 1'b1);
        check_bit("idle_busy", busy_o, 1'b0);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        #12;
        check_bit("rst_ready", dat_ready_o, 1'b1);
        check_bit("rst_valid", crc_valid_o, 1'b0);
        check_bit("rst_busy", busy_o, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Single byte 0x01 -> 0x07
        send_byte(8'h01, 1'b1);
        take_crc(0);

        // "123456789" -> 0xF4
        for (int i = 0; i < 9; i++) begin
            logic [7:0] b;
            b = 8'h31 + 8'(i);
            send_byte(b, i == 8);
        end
        take_crc(0);

        // 0xFF -> 0xF3 (0xA6 on the XOROUT=0x55 instance), held off for 10 cycles
        send_byte(8'hFF, 1'b1);
        take_crc(10);
        send_byte(8'h01, 1'b1);
        take_crc(0);

        // clr during slice 2 of 0x31: frame aborted
        dat_valid = 1'b1;
        dat       = 8'h31;
        dat_last  = 1'b1;
        tick();
        dat_valid = 1'b0;
        dat_last  = 1'b0;
        tick();
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_bit("clr_ready", dat_ready_o, 1'b1);
        check_bit("clr_busy", busy_o, 1'b0);
        for (int k = 0; k < 6; k++) begin
            check_bit("clr_no_valid", crc_valid_o, 1'b0);
            tick();
        end

        // clr beats a simultaneous accept
        clr       = 1'b1;
        dat_valid = 1'b1;
        dat       = 8'hAA;
        tick();
        clr       = 1'b0;
        dat_valid = 1'b0;
        check_bit("clr_blocks_accept", busy_o, 1'b0);
        send_byte(8'h01, 1'b1);
        take_crc(0);

        // Asynchronous reset in DONE
        send_byte(8'h01, 1'b1);
        void'(exp_q.pop_front());
        #2;
        rst = 1'b1;
        #1;
        check_bit("async_rst_valid", crc_valid_o, 1'b0);
        check_bit("async_rst_ready", dat_ready_o, 1'b1);
        check_bit("async_rst_busy", busy_o, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        send_byte(8'h01, 1'b1);
        take_crc(0);

        check_bit("scoreboard_empty", exp_q.size() == 0, 1'b1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
